// File: rtl/uart_rx.sv
// 8N1 UART receiver with programmable 1/8-bit prescale and an AXI-stream byte output.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error,
  input  logic [15:0]           prescale
);

  localparam int BitW = $clog2(DATA_WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic logic [15:0] clamp_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

  // Reload values are one less than the interval: the counter samples when it reaches zero.
  function automatic logic [18:0] half_bit_reload(input logic [15:0] p);
    return {1'b0, p, 2'b00} - 19'd1;
  endfunction

  function automatic logic [18:0] bit_reload(input logic [15:0] p);
    return {p, 3'b000} - 19'd1;
  endfunction

  logic [1:0]            sync_q;
  logic                  rxd_s;
  state_t                state_q, state_d;
  logic [18:0]           cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [15:0]           p_q, p_d;
  logic [15:0]           p_new;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  ovr_q;
  logic                  fe_q;
  logic                  byte_done;
  logic                  stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  pe_q;
  logic                  par_bad;
`endif

  assign rxd_s = sync_q[1];
  assign p_new = clamp_prescale(prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      p_q     <= 16'd1;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    p_d       = p_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_bad   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          p_d     = p_new;
          cnt_d   = half_bit_reload(p_new);
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = bit_reload(p_q);
            bit_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = bit_reload(p_q);
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          par_d   = rxd_s;
          cnt_d   = bit_reload(p_q);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit equals the XOR of the data bits.
            if (par_q != ^shift_q) par_bad = 1'b1;
            else                   byte_done = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end else begin
            // Low stop bit: park until the line idles so a break cannot retrigger.
            stop_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_BREAK: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q     <= 1'b0;
`endif
    end else begin
      if (byte_done) tdata_q <= shift_q;
      tvalid_q <= byte_done | (tvalid_q & ~m_axis_tready);
      ovr_q    <= byte_done & tvalid_q & ~m_axis_tready;
      fe_q     <= stop_bad;
`ifdef UART_RX_PARITY_EN
      pe_q     <= par_bad;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun_error = ovr_q;
  assign frame_error   = fe_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_BREAK);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames bit by bit and checks received bytes,
// latencies and error pulses against a cycle-count reference of the frame format.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int STOP_MUL = 84;
`else
  localparam int STOP_MUL = 76;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        tready = 1'b0;
  logic [15:0] prescale = 16'd1;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        busy;
  logic        ovr;
  logic        fe;
  logic        pe;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (ovr),
    .frame_error   (fe),
    .parity_error  (pe),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log: accepted bytes, error pulse counts and the cycles they occurred.
  logic [7:0] got[$];
  int n_fe = 0, n_ovr = 0, n_pe = 0;
  int last_rise = -1, last_fe = -1, last_ovr = -1, last_pe = -1;
  logic tv_prev = 1'b0;

  always @(negedge clk) begin
    if (tvalid && tready) got.push_back(tdata);
    if (fe)  begin n_fe++;  last_fe  = cyc; end
    if (ovr) begin n_ovr++; last_ovr = cyc; end
    if (pe)  begin n_pe++;  last_pe  = cyc; end
    if (tvalid && !tv_prev) last_rise = cyc;
    tv_prev = tvalid;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic drive_bit(input logic b, input int cycles);
    rxd = b;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Sends start, 8 data bits LSB first, [parity], stop; t0 is the cycle rxd first goes low.
  task automatic send(input logic [7:0] b, input logic stop_b, input logic par_b,
                      input int p, input bit scramble, output int t0);
    logic [10:0] fr;
    int nb;
`ifdef UART_RX_PARITY_EN
    fr = {stop_b, par_b, b, 1'b0};
    nb = 11;
`else
    fr = {par_b, stop_b, b, 1'b0};
    nb = 10;
`endif
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      drive_bit(fr[i], 8 * p);
      if (scramble && i == 0) prescale = 16'($urandom_range(0, 7));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_chk++; if (tdata !== 8'h00) $display("FAIL reset_tdata got=%h exp=00", tdata); else n_pass++;
    n_chk++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", tvalid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_chk++; if ({ovr, fe, pe} !== 3'b000) $display("FAIL reset_errors got=%b exp=000", {ovr, fe, pe}); else n_pass++;
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_basic();
    int t0, n0, fe0, ovr0;
    logic [7:0] b;
    prescale = 16'd1;
    tready = 1'b1;
    n0 = got.size(); fe0 = n_fe; ovr0 = n_ovr;
    send(8'hA5, 1'b1, ^8'hA5, 1, 1'b0, t0);
    idle(4);
    b = (got.size() > n0) ? got[n0] : 8'hxx;
    n_chk++; if (got.size() != n0 + 1) $display("FAIL basic_count got=%0d exp=%0d", got.size() - n0, 1); else n_pass++;
    n_chk++; if (b !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", b); else n_pass++;
    n_chk++; if (last_rise != t0 + 2 + 77) $display("FAIL basic_latency got=%0d exp=%0d", last_rise - t0 - 2, 77); else n_pass++;
    n_chk++; if (n_fe != fe0 || n_ovr != ovr0) $display("FAIL basic_errors got fe=%0d ovr=%0d exp 0 0", n_fe - fe0, n_ovr - ovr0); else n_pass++;
    n_chk++; if (tvalid !== 1'b0) $display("FAIL basic_tvalid_drop got=%b exp=0", tvalid); else n_pass++;
  endtask

  task automatic test_glitch();
    int t0, n0, fe0, r0;
    prescale = 16'd4;
    n0 = got.size(); fe0 = n_fe; r0 = last_rise;
    t0 = cyc;
    drive_bit(1'b0, 2);
    rxd = 1'b1;
    while (cyc < t0 + 3) begin @(posedge clk); #1; end
    n_chk++; if (busy !== 1'b1) $display("FAIL glitch_busy_rise got=%b exp=1", busy); else n_pass++;
    while (cyc < t0 + 2 + 16) begin @(posedge clk); #1; end
    n_chk++; if (busy !== 1'b1) $display("FAIL glitch_busy_c16 got=%b exp=1", busy); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL glitch_busy_c17 got=%b exp=0", busy); else n_pass++;
    idle(60);
    n_chk++; if (got.size() != n0 || last_rise != r0) $display("FAIL glitch_no_byte got=%0d exp=0", got.size() - n0); else n_pass++;
    n_chk++; if (n_fe != fe0 || busy !== 1'b0) $display("FAIL glitch_no_error got fe=%0d busy=%b exp 0 0", n_fe - fe0, busy); else n_pass++;
  endtask

  task automatic test_frame_error();
    int t0, t1, n0, fe0;
    logic [7:0] b;
    prescale = 16'd1;
    tready = 1'b1;
    n0 = got.size(); fe0 = n_fe;
    send(8'h3C, 1'b0, ^8'h3C, 1, 1'b0, t0);
    drive_bit(1'b0, 40);
    n_chk++; if (n_fe != fe0 + 1) $display("FAIL fe_count got=%0d exp=1", n_fe - fe0); else n_pass++;
    n_chk++; if (last_fe != t0 + 2 + 77) $display("FAIL fe_cycle got=%0d exp=%0d", last_fe - t0 - 2, 77); else n_pass++;
    n_chk++; if (got.size() != n0 || tvalid !== 1'b0) $display("FAIL fe_no_byte got=%0d tvalid=%b exp 0 0", got.size() - n0, tvalid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL fe_break_retrigger busy got=%b exp=0", busy); else n_pass++;
    idle(10);
    send(8'h55, 1'b1, ^8'h55, 1, 1'b0, t1);
    idle(4);
    b = (got.size() > n0) ? got[got.size() - 1] : 8'hxx;
    n_chk++; if (b !== 8'h55 || got.size() != n0 + 1) $display("FAIL fe_recover got=%h exp=55", b); else n_pass++;
    n_chk++; if (n_fe != fe0 + 1) $display("FAIL fe_single_pulse got=%0d exp=1", n_fe - fe0); else n_pass++;
  endtask

  task automatic test_overrun();
    int t0, t1, n0, ovr0;
    logic [7:0] b;
    prescale = 16'd1;
    tready = 1'b0;
    n0 = got.size(); ovr0 = n_ovr;
    send(8'h11, 1'b1, ^8'h11, 1, 1'b0, t0);
    n_chk++; if (tvalid !== 1'b1 || tdata !== 8'h11) $display("FAIL ovr_first got=%h v=%b exp=11 v=1", tdata, tvalid); else n_pass++;
    send(8'h22, 1'b1, ^8'h22, 1, 1'b0, t1);
    idle(4);
    n_chk++; if (tdata !== 8'h22 || tvalid !== 1'b1) $display("FAIL ovr_data got=%h v=%b exp=22 v=1", tdata, tvalid); else n_pass++;
    n_chk++; if (n_ovr != ovr0 + 1) $display("FAIL ovr_count got=%0d exp=1", n_ovr - ovr0); else n_pass++;
    n_chk++; if (last_ovr != t1 + 2 + 77) $display("FAIL ovr_cycle got=%0d exp=%0d", last_ovr - t1 - 2, 77); else n_pass++;
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    b = (got.size() > n0) ? got[n0] : 8'hxx;
    n_chk++; if (got.size() != n0 + 1 || b !== 8'h22) $display("FAIL ovr_transfer got=%h n=%0d exp=22 n=1", b, got.size() - n0); else n_pass++;
    n_chk++; if (tvalid !== 1'b0) $display("FAIL ovr_tvalid_drop got=%b exp=0", tvalid); else n_pass++;
    idle(4);
  endtask

  task automatic test_reset_midframe();
    int t1, n0, fe0;
    logic [7:0] b;
    prescale = 16'd1;
    tready = 1'b1;
    n0 = got.size(); fe0 = n_fe;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 28);
    n_chk++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({tvalid, busy, ovr, fe, pe} !== 5'b0 || tdata !== 8'h00)
      $display("FAIL rstmid_outputs got=%h %b exp=00 00000", tdata, {tvalid, busy, ovr, fe, pe}); else n_pass++;
    idle(2);
    rst = 1'b0;
    idle(80);
    send(8'h5A, 1'b1, ^8'h5A, 1, 1'b0, t1);
    idle(4);
    b = (got.size() > n0) ? got[n0] : 8'hxx;
    n_chk++; if (got.size() != n0 + 1 || b !== 8'h5A) $display("FAIL rstmid_next got=%h n=%0d exp=5a n=1", b, got.size() - n0); else n_pass++;
    n_chk++; if (n_fe != fe0) $display("FAIL rstmid_no_fe got=%0d exp=0", n_fe - fe0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int t0, n0, pe0, fe0, pr, p_eff;
    tready = 1'b1;
    n0 = got.size(); pe0 = n_pe; fe0 = n_fe;
    for (int k = 0; k < 8; k++) begin
      pr = $urandom_range(0, 3);
      p_eff = (pr == 0) ? 1 : pr;
      b = 8'($urandom);
      exp_q.push_back(b);
      prescale = 16'(pr);
      send(b, 1'b1, ^b, p_eff, 1'b1, t0);
      n_chk++; if (last_rise != t0 + 2 + STOP_MUL * p_eff + 1)
        $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, last_rise - t0 - 2, STOP_MUL * p_eff + 1); else n_pass++;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
    end
    idle(4);
    n_chk++; if (got.size() != n0 + exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", got.size() - n0, exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      b = (got.size() > n0 + k) ? got[n0 + k] : 8'hxx;
      n_chk++; if (b !== exp_q[k]) $display("FAIL b2b_data[%0d] got=%h exp=%h", k, b, exp_q[k]); else n_pass++;
    end
    n_chk++; if (n_pe != pe0 || n_fe != fe0) $display("FAIL b2b_errors got pe=%0d fe=%0d exp 0 0", n_pe - pe0, n_fe - fe0); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t0, n0, pe0;
    logic [7:0] b;
    prescale = 16'd1;
    tready = 1'b1;
    n0 = got.size(); pe0 = n_pe;
    send(8'h07, 1'b1, 1'b1, 1, 1'b0, t0);
    idle(4);
    b = (got.size() > n0) ? got[n0] : 8'hxx;
    n_chk++; if (b !== 8'h07) $display("FAIL par_good_data got=%h exp=07", b); else n_pass++;
    n_chk++; if (last_rise != t0 + 2 + 85) $display("FAIL par_good_latency got=%0d exp=85", last_rise - t0 - 2); else n_pass++;
    send(8'h07, 1'b1, 1'b0, 1, 1'b0, t0);
    idle(4);
    n_chk++; if (n_pe != pe0 + 1 || last_pe != t0 + 2 + 85) $display("FAIL par_bad_pulse got=%0d exp=1", n_pe - pe0); else n_pass++;
    n_chk++; if (got.size() != n0 + 1 || tvalid !== 1'b0) $display("FAIL par_bad_discard got=%0d exp=1", got.size() - n0); else n_pass++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
